// File: rtl/lrsc_reservation_unit.sv
// LR/SC reservation tracker for the barrel core MEM stage.
// Optional macro RESV_TIMEOUT_EN: per-hart reservation lifetime counters.
module lrsc_reservation_unit #(
    parameter int NUM_HARTS    = 16,
    parameter int ADDR_W       = 32,
    parameter int RESV_TIMEOUT = 255,
    localparam int HART_W      = $clog2(NUM_HARTS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [HART_W-1:0] i_hart_id,
    input  logic              i_lr,
    input  logic              i_sc,
    input  logic              i_store,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_sc_mem_we,
    output logic              o_sc_resp_valid,
    output logic [31:0]       o_sc_result,
    output logic [NUM_HARTS-1:0] o_resv_valid
);

    logic [NUM_HARTS-1:0] r_valid;
    logic [ADDR_W-3:0]    r_addr [NUM_HARTS];
    logic                 r_resp_valid;
    logic                 r_resp_fail;

    logic [ADDR_W-3:0]    w_word;
    logic [NUM_HARTS-1:0] w_match;
    logic                 w_sc_ok;
    logic                 w_do_st;
    logic                 w_do_lr;

    assign w_word  = i_addr[ADDR_W-1:2];
    assign w_do_st = !i_sc && i_store;
    assign w_do_lr = !i_sc && !i_store && i_lr;

    // Per-hart word-address match against the live reservations.
    always_comb begin
        w_match = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_match[h] = r_valid[h] && (r_addr[h] == w_word);
        end
    end

    assign w_sc_ok     = i_sc && w_match[i_hart_id];
    assign o_sc_mem_we = w_sc_ok && !i_reset;

`ifdef RESV_TIMEOUT_EN
    localparam int CNT_W = $clog2(RESV_TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt [NUM_HARTS];

    // Reservation state; explicit LR/SC/store updates override expiry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_addr[h] <= '0;
                r_cnt[h]  <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (r_valid[h] && (r_cnt[h] != '0)) begin
                    r_cnt[h] <= r_cnt[h] - CNT_W'(1);
                end
                if (r_valid[h] && (r_cnt[h] <= CNT_W'(1))) begin
                    r_valid[h] <= 1'b0;
                end
                if (w_do_lr && (i_hart_id == HART_W'(h))) begin
                    r_valid[h] <= 1'b1;
                    r_addr[h]  <= w_word;
                    r_cnt[h]   <= CNT_W'(RESV_TIMEOUT);
                end
                if (i_sc && (i_hart_id == HART_W'(h))) begin
                    r_valid[h] <= 1'b0;
                end
                if ((w_sc_ok || w_do_st) && w_match[h]) begin
                    r_valid[h] <= 1'b0;
                end
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{1'b0, 32'(RESV_TIMEOUT)};

    // Reservation state; entries live until SC, matching store or reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_addr[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_do_lr && (i_hart_id == HART_W'(h))) begin
                    r_valid[h] <= 1'b1;
                    r_addr[h]  <= w_word;
                end
                if (i_sc && (i_hart_id == HART_W'(h))) begin
                    r_valid[h] <= 1'b0;
                end
                if ((w_sc_ok || w_do_st) && w_match[h]) begin
                    r_valid[h] <= 1'b0;
                end
            end
        end
    end
`endif

    logic w_unused_addr;
    assign w_unused_addr = ^{1'b0, i_addr[1:0]};

    // One-cycle SC response pulse; result is 1 only for a failed SC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_resp_valid <= 1'b0;
            r_resp_fail  <= 1'b0;
        end else begin
            r_resp_valid <= i_sc;
            r_resp_fail  <= i_sc && !w_sc_ok;
        end
    end

    assign o_sc_resp_valid = r_resp_valid;
    assign o_sc_result     = {31'b0, r_resp_fail};
    assign o_resv_valid    = r_valid;

endmodule

// File: tb/tb_lrsc_reservation_unit.sv
// Randomized bench for lrsc_reservation_unit against a reservation model.
// Model keeps per-hart word address and LR timestamp.
module tb_lrsc_reservation_unit;

    localparam int NH = 16;
    localparam int AW = 32;
`ifdef RESV_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [3:0]    i_hart_id = '0;
    logic          i_lr = 1'b0;
    logic          i_sc = 1'b0;
    logic          i_store = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          o_sc_mem_we;
    logic          o_sc_resp_valid;
    logic [31:0]   o_sc_result;
    logic [NH-1:0] o_resv_valid;

    lrsc_reservation_unit #(
        .NUM_HARTS(NH),
        .ADDR_W(AW),
        .RESV_TIMEOUT(TMO)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_hart_id(i_hart_id),
        .i_lr(i_lr),
        .i_sc(i_sc),
        .i_store(i_store),
        .i_addr(i_addr),
        .o_sc_mem_we(o_sc_mem_we),
        .o_sc_resp_valid(o_sc_resp_valid),
        .o_sc_result(o_sc_result),
        .o_resv_valid(o_resv_valid)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_fail = 0;
    int now    = 0;

    bit          m_v  [NH];
    logic [29:0] m_a  [NH];
    int          m_ts [NH];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, now);
        end
    endtask

    function automatic bit alive(input int h);
`ifdef RESV_TIMEOUT_EN
        return m_v[h] && ((now - m_ts[h]) <= TMO);
`else
        return m_v[h];
`endif
    endfunction

    function automatic bit hit(input int h, input logic [31:0] a);
        return alive(h) && (m_a[h] == a[31:2]);
    endfunction

    function automatic logic [NH-1:0] mvec();
        logic [NH-1:0] v;
        for (int h = 0; h < NH; h++) v[h] = alive(h);
        return v;
    endfunction

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_lr = 1'b0;
        i_sc = 1'b0;
        i_store = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        for (int h = 0; h < NH; h++) begin
            m_v[h] = 1'b0;
            m_a[h] = '0;
            m_ts[h] = 0;
        end
        now++;
        check("rst_resv", o_resv_valid, '0);
        check("rst_rv", o_sc_resp_valid, 0);
        check("rst_res", o_sc_result, 0);
        check("rst_we", o_sc_mem_we, 0);
    endtask

    task automatic step(input int h, input bit lr, input bit sc,
                        input bit st, input logic [31:0] a);
        bit ok;
        bit hits [NH];
        i_hart_id = 4'(h);
        i_lr = lr;
        i_sc = sc;
        i_store = st;
        i_addr = a;
        #1;
        ok = sc && hit(h, a);
        for (int k = 0; k < NH; k++) hits[k] = hit(k, a);
        check("sc_we", o_sc_mem_we, ok);
        @(posedge i_clk);
        #1;
        if (sc) begin
            if (ok) begin
                for (int k = 0; k < NH; k++)
                    if (hits[k]) m_v[k] = 1'b0;
            end
            m_v[h] = 1'b0;
        end else if (st) begin
            for (int k = 0; k < NH; k++)
                if (hits[k]) m_v[k] = 1'b0;
        end else if (lr) begin
            m_v[h] = 1'b1;
            m_a[h] = a[31:2];
            m_ts[h] = now;
        end
        now++;
        i_lr = 1'b0;
        i_sc = 1'b0;
        i_store = 1'b0;
        check("resp_v", o_sc_resp_valid, sc);
        check("result", o_sc_result, (sc && !ok) ? 1 : 0);
        check("resv", o_resv_valid, mvec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
    endtask

    logic [31:0] pool [4];

    initial begin
        pool[0] = 32'h40;
        pool[1] = 32'h1000;
        pool[2] = 32'h2000;
        pool[3] = 32'h104;

        do_reset();

        step(3, 1, 0, 0, 32'h1000);
        idle(2);
        step(3, 0, 1, 0, 32'h1000);
        check("t1_res", o_sc_result, 0);
        check("t1_v3", {31'b0, o_resv_valid[3]}, 0);
        step(3, 0, 0, 0, 32'h0);
        check("t1_drop", o_sc_resp_valid, 0);

        step(2, 1, 0, 0, 32'h2000);
        step(5, 0, 0, 1, 32'h2002);
        step(2, 0, 1, 0, 32'h2000);
        check("t2_res", o_sc_result, 1);

        step(0, 1, 0, 0, 32'h40);
        step(1, 1, 0, 0, 32'h43);
        step(0, 0, 1, 0, 32'h40);
        check("t3_vec", o_resv_valid, 16'h0000);
        step(1, 0, 1, 0, 32'h40);
        check("t3_res", o_sc_result, 1);

        step(4, 0, 1, 0, 32'h100);
        step(4, 1, 0, 0, 32'h100);
        step(4, 0, 1, 0, 32'h104);
        check("t4_v4", {31'b0, o_resv_valid[4]}, 0);

        step(6, 1, 0, 0, 32'h300);
        step(6, 1, 1, 0, 32'h300);
        check("t5_res", o_sc_result, 0);
        check("t5_v6", {31'b0, o_resv_valid[6]}, 0);

        step(7, 1, 0, 0, 32'h500);
        do_reset();
        step(7, 0, 1, 0, 32'h500);
        check("t6_res", o_sc_result, 1);

        step(8, 1, 0, 1, 32'h600);
        check("t7_prio", {31'b0, o_resv_valid[8]}, 0);

`ifdef RESV_TIMEOUT_EN
        step(9, 1, 0, 0, 32'h700);
        idle(7);
        step(9, 0, 1, 0, 32'h700);
        check("tmo8", o_sc_result, 0);
        step(9, 1, 0, 0, 32'h700);
        idle(8);
        step(9, 0, 1, 0, 32'h700);
        check("tmo9", o_sc_result, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            int h;
            bit lr, sc, st;
            logic [31:0] a;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                h  = int'($urandom_range(0, (i % 3 == 0) ? 15 : 3));
                a  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
                lr = ($urandom_range(0, 2) == 0);
                sc = ($urandom_range(0, 3) == 0);
                st = ($urandom_range(0, 5) == 0);
                step(h, lr, sc, st, a);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
